// File: rtl/au_mult_seq.sv
// Sequential unsigned shift-and-add multiplier: one ripple adder is reused over
// WIDTH iterations to build a 2*WIDTH-bit product behind a start/busy/done handshake.

module adder_4bit #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    logic [WIDTH:0] carry;

    assign carry[0] = cin;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_rca
            assign sum[gi]       = a[gi] ^ b[gi] ^ carry[gi];
            assign carry[gi + 1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign cout = carry[WIDTH];
endmodule

module au_mult_seq #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic [WIDTH-1:0]   m_reg, acc_reg, q_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [2*WIDTH-1:0] product_reg;

    logic [WIDTH-1:0]   add_sum;
    logic               add_cout;
    logic [WIDTH:0]     step;
    logic [WIDTH-1:0]   acc_next, q_next;
    logic               last_iter;

    adder_4bit #(.WIDTH(WIDTH)) u_adder (
        .a    (acc_reg),
        .b    (m_reg),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // The adder carry becomes the top bit shifted into ACC, so nothing is lost.
    assign step      = q_reg[0] ? {add_cout, add_sum} : {1'b0, acc_reg};
    assign acc_next  = step[WIDTH:1];
    assign q_next    = {step[0], q_reg[WIDTH-1:1]};
    assign last_iter = (cnt_reg == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_iter) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_reg)
            RUN:     busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_reg       <= '0;
            acc_reg     <= '0;
            q_reg       <= '0;
            cnt_reg     <= '0;
            product_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        m_reg   <= a;
                        q_reg   <= b;
                        acc_reg <= '0;
                        cnt_reg <= '0;
                    end
                end
                RUN: begin
                    acc_reg <= acc_next;
                    q_reg   <= q_next;
                    cnt_reg <= cnt_reg + 1'b1;
                    // Product only changes on the final iteration; held otherwise.
                    if (last_iter) product_reg <= {acc_next, q_next};
                end
                default: ;
            endcase
        end
    end

    assign product = product_reg;
endmodule

// File: tb/tb_au_mult_seq.sv
// Directed bench for au_mult_seq: handshake timing, start filtering, async
// reset abort, continuous start, and all 256 operand pairs.

module tb_au_mult_seq;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] a = 4'd0;
    logic [3:0] b = 4'd0;
    logic       busy;
    logic       done;
    logic [7:0] product;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_prod = 8'h00;

    always #5 clk = ~clk;

    au_mult_seq #(.WIDTH(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One transaction: start pulse at E0, then observe six cycles. With poke set,
    // a second start (15x15) is pulsed during RUN and must be ignored.
    task automatic run_op(input logic [3:0] av, input logic [3:0] bv, input logic [7:0] want,
                          input bit poke, input string tag);
        int busy_cnt, done_cnt, done_at, overlap, held_bad;
        busy_cnt = 0; done_cnt = 0; done_at = -1; overlap = 0; held_bad = 0;
        @(negedge clk);
        a = av; b = bv; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = ~av; b = ~bv;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (poke && i == 1) begin start = 1'b1; a = 4'hF; b = 4'hF; end
            if (poke && i == 2) start = 1'b0;
            if (busy && done) overlap++;
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_at < 0) done_at = i;
            end
            if (i < 4 && product !== exp_prod) held_bad++;
            if (i == 4) check_value({tag, "_product"}, product, want);
        end
        start = 1'b0;
        exp_prod = want;
        check_value({tag, "_busy_cycles"}, busy_cnt, 4);
        check_value({tag, "_done_latency"}, done_at, 4);
        check_value({tag, "_done_count"}, done_cnt, 1);
        check_value({tag, "_overlap"}, overlap, 0);
        check_value({tag, "_held"}, held_bad, 0);
        $display("op %s a=%0d b=%0d product=%0h expected=%0h", tag, av, bv, product, want);
    endtask

    initial begin
        // Reset state
        #12;
        check_value("rst_busy", busy, 0);
        check_value("rst_done", done, 0);
        check_value("rst_product", product, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic products
        run_op(4'd15, 4'd15, 8'hE1, 1'b0, "t1_15x15");
        run_op(4'd9,  4'd11, 8'h63, 1'b0, "t2_9x11");
        run_op(4'd0,  4'd13, 8'h00, 1'b0, "t2_0x13");
        run_op(4'd7,  4'd1,  8'h07, 1'b0, "t2_7x1");

        // Start during RUN is ignored
        run_op(4'd3, 4'd5, 8'h0F, 1'b1, "t3_ignore");

        // Async reset in the 2nd RUN cycle aborts the operation
        @(negedge clk);
        a = 4'd12; b = 4'd12; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_value("t4_busy_abort", busy, 0);
        check_value("t4_done_abort", done, 0);
        check_value("t4_product_abort", product, 8'h00);
        exp_prod = 8'h00;
        @(negedge clk);
        begin
            int stray;
            stray = 0;
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                if (done || busy) stray++;
            end
            check_value("t4_no_done_in_reset", stray, 0);
        end
        rst_n = 1'b1;
        run_op(4'd2, 4'd3, 8'h06, 1'b0, "t4_after");

        // start held high: back-to-back operations every 6 cycles
        @(negedge clk);
        a = 4'd6; b = 4'd7; start = 1'b1;
        @(posedge clk);
        begin
            int done_cnt, pos_bad, prod_bad, overlap, consec;
            logic prev_done;
            done_cnt = 0; pos_bad = 0; prod_bad = 0; overlap = 0; consec = 0; prev_done = 1'b0;
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                if (busy && done) overlap++;
                if (done && prev_done) consec++;
                if (done) begin
                    done_cnt++;
                    if (k % 6 != 4) pos_bad++;
                    if (product !== 8'h2A) prod_bad++;
                end
                prev_done = done;
            end
            start = 1'b0;
            check_value("t5_done_count", done_cnt, 3);
            check_value("t5_done_position", pos_bad, 0);
            check_value("t5_product", prod_bad, 0);
            check_value("t5_overlap", overlap, 0);
            check_value("t5_consecutive_done", consec, 0);
            $display("op t5_held a=6 b=7 dones=%0d product=%0h expected=2a", done_cnt, product);
        end
        for (int i = 0; i < 8; i++) @(negedge clk);
        check_value("t5_idle_busy", busy, 0);
        exp_prod = 8'h2A;

        // Exhaustive against a*b
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                logic [7:0] ref_p;
                logic [3:0] xa, yb;
                ref_p = 8'(x * y);
                xa = 4'(x);
                yb = 4'(y);
                run_op(xa, yb, ref_p, 1'b0, "t6");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
